// File: rtl/io_switch.sv
// io_switch: I/O region switch for the RISC5 bus.
//
// Decodes an aligned window of NSLV * 2^SLOT_LOG words starting at BASE_W
// into NSLV equal slots. The selected slot gets a registered strobe together
// with registered write enable, address and write data. Its acknowledge and
// read data come back to the CPU as a single registered response. If the slot
// never acknowledges, the access ends after TMO_CYC strobe cycles. The CPU
// then gets an ack with zero data, and the sticky error flag captures the
// address.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   bus_stb/we      CPU strobe and write enable
//   bus_addr        CPU word address (byte address bits [23:2])
//   bus_dout        CPU write data
//   io_hit          combinational: strobe is high and address is in window
//   io_din, io_ack  registered read data / one-cycle acknowledge to CPU
//   slv_stb         one-hot registered slot strobes
//   slv_we/addr/data registered write enable, word address, write data
//   slv_dout        per-slot read data, slot i at [32*i+31:32*i]
//   slv_ack         per-slot acknowledges
//   err_clr         clears the sticky error flag
//   err, err_addr   sticky timeout flag and address of last timed-out access
module io_switch #(
  parameter int unsigned NSLV     = 8,
  parameter int unsigned SLOT_LOG = 1,
  parameter logic [21:0] BASE_W   = 22'h3FFFE0,
  parameter int unsigned TMO_CYC  = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bus_stb,
  input  logic               bus_we,
  input  logic [21:0]        bus_addr,
  input  logic [31:0]        bus_dout,
  output logic               io_hit,
  output logic [31:0]        io_din,
  output logic               io_ack,
  output logic [NSLV-1:0]    slv_stb,
  output logic               slv_we,
  output logic [21:0]        slv_addr,
  output logic [31:0]        slv_data,
  input  logic [NSLV*32-1:0] slv_dout,
  input  logic [NSLV-1:0]    slv_ack,
  input  logic               err_clr,
  output logic               err,
  output logic [21:0]        err_addr
);

  localparam int unsigned IDX_BITS = $clog2(NSLV);
  localparam int unsigned W        = IDX_BITS + SLOT_LOG;
  // A single-slot switch still needs a 1-bit index register.
  localparam int unsigned IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int unsigned CNT_W    = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NSLV-1:0]   stb_q;
  logic              we_q;
  logic [21:0]       addr_q;
  logic [31:0]       data_q;
  logic              ack_q;
  logic [31:0]       din_q;
  logic              err_q;
  logic [21:0]       err_addr_q;

  logic              in_win_d;
  logic [IDX_W-1:0]  idx_d;
  logic [NSLV-1:0]   onehot_d;
  logic [31:0]       slot_data [NSLV];
  logic              sel_ack_d;
  logic              tmo_hit_d;
  logic              err_d;

  // Window match compares only the bits above the slot-index field.
  assign in_win_d = ((bus_addr >> W) == (BASE_W >> W));
  assign idx_d    = IDX_W'(bus_addr >> SLOT_LOG) & IDX_W'(NSLV - 1);

  for (genvar gi = 0; gi < NSLV; gi++) begin : g_slot
    assign slot_data[gi] = slv_dout[32*gi +: 32];
    assign onehot_d[gi]  = (idx_d == IDX_W'(gi));
  end

  // Only the slot that owns the current access may complete it.
  assign sel_ack_d = slv_ack[idx_q];

  // Timeout fires in the TMO_CYC-th strobe cycle unless the slot acks in it.
  assign tmo_hit_d = (state_q == ACTIVE) && bus_stb && !sel_ack_d &&
                     (cnt_q == CNT_LAST);

  // Set wins over clear.
  assign err_d = tmo_hit_d | (err_q & ~err_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      stb_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      ack_q      <= 1'b0;
      din_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q <= err_d;
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          if (bus_stb && in_win_d) begin
            stb_q   <= onehot_d;
            we_q    <= bus_we;
            addr_q  <= bus_addr;
            data_q  <= bus_dout;
            idx_q   <= idx_d;
            cnt_q   <= '0;
            state_q <= ACTIVE;
          end else begin
            stb_q <= '0;
          end
        end
        ACTIVE: begin
          if (!bus_stb) begin
            // Master withdrew the request: abort without acknowledging.
            stb_q   <= '0;
            state_q <= IDLE;
          end else if (sel_ack_d) begin
            din_q   <= slot_data[idx_q];
            ack_q   <= 1'b1;
            stb_q   <= '0;
            state_q <= DONE;
          end else if (tmo_hit_d) begin
            din_q      <= '0;
            ack_q      <= 1'b1;
            stb_q      <= '0;
            err_addr_q <= addr_q;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          stb_q   <= '0;
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign io_hit   = bus_stb & in_win_d;
  assign io_din   = din_q;
  assign io_ack   = ack_q;
  assign slv_stb  = stb_q;
  assign slv_we   = we_q;
  assign slv_addr = addr_q;
  assign slv_data = data_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;

endmodule
